// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 size codes, exception codes,
// controller states and the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_SIZE     = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_e;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic int unsigned size_bytes(input logic [1:0] sz);
        return 32'd1 << sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: size/alignment checks, byte enables, store-data
// replication and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic                       is_store,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            wdata,
    output logic                       bad_size,
    output logic                       misaligned,
    output logic [XLEN/8-1:0]          be,
    output logic [XLEN-1:0]            wdata_rep,
    input  logic [2:0]                 ld_funct3,
    input  logic [$clog2(XLEN/8)-1:0]  ld_off,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN-1:0]            ld_data
);

    localparam int NB = XLEN / 8;

    int unsigned         bytes;
    int unsigned         nbits;
    logic [NB-1:0]       mask;
    logic [XLEN-1:0]     shifted;
    logic                top_bit;
    logic                sext;

    always_comb begin
        bytes      = size_bytes(funct3[1:0]);
        bad_size   = (funct3 == 3'b111) || (is_store && funct3[2]) ||
                     ((XLEN == 32) && ((funct3 == F3_D) || (funct3 == F3_WU)));
        misaligned = !bad_size && ((32'(off) & (bytes - 32'd1)) != 32'd0);

        mask = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            mask[i] = (i < bytes);
        end
        be = mask << off;

        wdata_rep = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            case (funct3[1:0])
                2'b00:   wdata_rep[8*i +: 8] = wdata[7:0];
                2'b01:   wdata_rep[8*i +: 8] = wdata[8*(i%2) +: 8];
                2'b10:   wdata_rep[8*i +: 8] = wdata[8*(i%4) +: 8];
                default: wdata_rep[8*i +: 8] = wdata[8*(i%8) +: 8];
            endcase
        end
    end

    // Doubleword loads fill the whole register, so they never extend
    always_comb begin
        shifted = rdata >> {ld_off, 3'b000};
        nbits   = XLEN;
        top_bit = 1'b0;
        case (ld_funct3[1:0])
            2'b00:   begin nbits = 8;  top_bit = shifted[7];  end
            2'b01:   begin nbits = 16; top_bit = shifted[15]; end
            2'b10:   begin nbits = 32; top_bit = shifted[31]; end
            default: begin nbits = XLEN; top_bit = 1'b0; end
        endcase
        sext    = top_bit && !ld_funct3[2];
        ld_data = '0;
        for (int unsigned i = 0; i < XLEN; i++) begin
            ld_data[i] = (i < nbits) ? shifted[i] : sext;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: captures an EX memory op, runs the request/response
// handshake, stalls the pipeline and reports exceptions.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 ex_load,
    input  logic                 ex_store,
    input  logic [2:0]           ex_funct3,
    input  logic [ADDR_W-1:0]    ex_addr,
    input  logic [XLEN-1:0]      ex_wdata,
    input  logic                 flush,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [XLEN/8-1:0]    mem_req_be,
    output logic [XLEN-1:0]      mem_req_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rsp_rdata,
    output logic                 lsu_stall,
    output logic                 ld_valid,
    output logic [XLEN-1:0]      ld_data,
    output logic                 exc_valid,
    output logic [1:0]           exc_code
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    lsu_state_e          state, state_next;
    logic                hold_we;
    logic [2:0]          hold_f3;
    logic [OW-1:0]       hold_off;
    logic [NB-1:0]       hold_be;
    logic [XLEN-1:0]     hold_wdata;
    logic [ADDR_W-1:0]   hold_addr;
    logic                kill;
    logic [TW-1:0]       timer;
    logic                exc_valid_r;
    logic [1:0]          exc_code_r;

    logic                bad_size, misaligned;
    logic [NB-1:0]       be_c;
    logic [XLEN-1:0]     wdata_c;
    logic [XLEN-1:0]     ld_ext;
    logic                accept, capture, timeout, time_exc;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (ex_funct3),
        .is_store   (ex_store),
        .off        (ex_addr[OW-1:0]),
        .wdata      (ex_wdata),
        .bad_size   (bad_size),
        .misaligned (misaligned),
        .be         (be_c),
        .wdata_rep  (wdata_c),
        .ld_funct3  (hold_f3),
        .ld_off     (hold_off),
        .rdata      (mem_rsp_rdata),
        .ld_data    (ld_ext)
    );

    always_comb begin
        accept     = (state == IDLE) && ex_valid && (ex_load || ex_store) && !flush;
        capture    = accept && !bad_size && !misaligned;
        timeout    = (MAX_WAIT != 0) && (timer == TW'(MAX_WAIT - 1));
        time_exc   = 1'b0;
        state_next = state;
        mem_req_valid = 1'b0;
        lsu_stall  = 1'b0;
        ld_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (capture) state_next = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                lsu_stall     = !(mem_req_ready && hold_we);
                if (mem_req_ready) begin
                    state_next = hold_we ? IDLE : WAIT;
                end else if (timeout) begin
                    time_exc   = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT: begin
                lsu_stall = !mem_rsp_valid;
                if (mem_rsp_valid) begin
                    ld_valid   = !kill && !flush;
                    state_next = IDLE;
                end else if (timeout) begin
                    time_exc   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        ld_data = ld_valid ? ld_ext : '0;
    end

    assign mem_req_we    = hold_we;
    assign mem_req_addr  = hold_addr;
    assign mem_req_be    = hold_be;
    assign mem_req_wdata = hold_wdata;
    assign exc_valid     = exc_valid_r;
    assign exc_code      = exc_code_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_we     <= 1'b0;
            hold_f3     <= '0;
            hold_off    <= '0;
            hold_be     <= '0;
            hold_wdata  <= '0;
            hold_addr   <= '0;
            kill        <= 1'b0;
            timer       <= '0;
            exc_valid_r <= 1'b0;
            exc_code_r  <= EXC_NONE;
        end else begin
            state       <= state_next;
            exc_valid_r <= 1'b0;
            exc_code_r  <= EXC_NONE;
            if (accept && bad_size) begin
                exc_valid_r <= 1'b1;
                exc_code_r  <= EXC_SIZE;
            end else if (accept && misaligned) begin
                exc_valid_r <= 1'b1;
                exc_code_r  <= EXC_MISALIGN;
            end else if (time_exc) begin
                exc_valid_r <= 1'b1;
                exc_code_r  <= EXC_TIMEOUT;
            end

            if (capture) begin
                hold_we    <= ex_store;
                hold_f3    <= ex_funct3;
                hold_off   <= ex_addr[OW-1:0];
                hold_be    <= be_c;
                hold_wdata <= wdata_c;
                hold_addr  <= {ex_addr[ADDR_W-1:OW], {OW{1'b0}}};
                kill       <= 1'b0;
            end else if ((state != IDLE) && flush && !hold_we) begin
                kill <= 1'b1;
            end

            // Timer restarts on entry to REQ and again on entry to WAIT
            if (capture || ((state == REQ) && mem_req_ready && !hold_we)) begin
                timer <= '0;
            end else if (state != IDLE) begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit instance (MAX_WAIT=15) and a 64-bit
// instance (MAX_WAIT=4) with hand-computed expectations.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit instance signals
    logic        a_ex_valid = 0, a_ex_load = 0, a_ex_store = 0, a_flush = 0;
    logic [2:0]  a_funct3 = '0;
    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata = '0;
    logic        a_ready = 0, a_rsp_valid = 0;
    logic        a_req_valid, a_we, a_stall, a_ld_valid, a_exc_valid;
    logic [31:0] a_req_addr, a_req_wdata, a_ld_data;
    logic [3:0]  a_be;
    logic [1:0]  a_exc_code;

    // 64-bit instance signals
    logic        b_ex_valid = 0, b_ex_load = 0, b_ex_store = 0, b_flush = 0;
    logic [2:0]  b_funct3 = '0;
    logic [31:0] b_addr = '0;
    logic [63:0] b_wdata = '0, b_rdata = '0;
    logic        b_ready = 0, b_rsp_valid = 0;
    logic        b_req_valid, b_we, b_stall, b_ld_valid, b_exc_valid;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata, b_ld_data;
    logic [7:0]  b_be;
    logic [1:0]  b_exc_code;

    lsu_ctrl #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(15)) dut_a (
        .clk(clk), .rst(rst),
        .ex_valid(a_ex_valid), .ex_load(a_ex_load), .ex_store(a_ex_store),
        .ex_funct3(a_funct3), .ex_addr(a_addr), .ex_wdata(a_wdata), .flush(a_flush),
        .mem_req_valid(a_req_valid), .mem_req_ready(a_ready), .mem_req_we(a_we),
        .mem_req_addr(a_req_addr), .mem_req_be(a_be), .mem_req_wdata(a_req_wdata),
        .mem_rsp_valid(a_rsp_valid), .mem_rsp_rdata(a_rdata),
        .lsu_stall(a_stall), .ld_valid(a_ld_valid), .ld_data(a_ld_data),
        .exc_valid(a_exc_valid), .exc_code(a_exc_code)
    );

    lsu_ctrl #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(4)) dut_b (
        .clk(clk), .rst(rst),
        .ex_valid(b_ex_valid), .ex_load(b_ex_load), .ex_store(b_ex_store),
        .ex_funct3(b_funct3), .ex_addr(b_addr), .ex_wdata(b_wdata), .flush(b_flush),
        .mem_req_valid(b_req_valid), .mem_req_ready(b_ready), .mem_req_we(b_we),
        .mem_req_addr(b_req_addr), .mem_req_be(b_be), .mem_req_wdata(b_req_wdata),
        .mem_rsp_valid(b_rsp_valid), .mem_rsp_rdata(b_rdata),
        .lsu_stall(b_stall), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
        .exc_valid(b_exc_valid), .exc_code(b_exc_code)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic a_drive(input logic load, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        a_ex_valid = 1; a_ex_load = load; a_ex_store = !load;
        a_funct3 = f3; a_addr = addr; a_wdata = wd;
        #1 check("idle_stall", 64'(a_stall), 64'd0);
        @(negedge clk);
        a_ex_valid = 0; a_ex_load = 0; a_ex_store = 0;
        #1;
    endtask

    task automatic a_store_zw(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_addr);
        a_ready = 1;
        a_drive(1'b0, f3, addr, wd);
        check({tag, "_valid"}, 64'(a_req_valid), 64'd1);
        check({tag, "_we"},    64'(a_we), 64'd1);
        check({tag, "_be"},    64'(a_be), 64'(exp_be));
        check({tag, "_addr"},  64'(a_req_addr), 64'(exp_addr));
        check({tag, "_wdata"}, 64'(a_req_wdata), 64'(exp_wd));
        check({tag, "_stall"}, 64'(a_stall), 64'd0);
        @(negedge clk); a_ready = 0;
        #1 check({tag, "_done"}, 64'(a_req_valid), 64'd0);
    endtask

    task automatic a_load_zw(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rd, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
        a_ready = 1;
        a_drive(1'b1, f3, addr, 32'd0);
        check({tag, "_be"}, 64'(a_be), 64'(exp_be));
        check({tag, "_stall_req"}, 64'(a_stall), 64'd1);
        @(negedge clk); a_ready = 0; a_rsp_valid = 1; a_rdata = rd;
        #1 check({tag, "_ldv"}, 64'(a_ld_valid), 64'd1);
        check({tag, "_data"}, 64'(a_ld_data), 64'(exp_data));
        check({tag, "_stall_rsp"}, 64'(a_stall), 64'd0);
        @(negedge clk); a_rsp_valid = 0;
        #1 check({tag, "_ldv_end"}, 64'(a_ld_valid), 64'd0);
    endtask

    initial begin
        int stalls;
        int reqs;
        logic saw_exc;
        logic [1:0] exc_seen;

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 64'(a_req_valid), 64'd0);
        check("rst_stall",     64'(a_stall), 64'd0);
        check("rst_exc",       64'(a_exc_valid), 64'd0);
        check("rst_be",        64'(a_be), 64'd0);
        check("rst_b_valid",   64'(b_req_valid), 64'd0);
        @(negedge clk); rst = 0;

        a_store_zw("sw",  3'b010, 32'h104, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h104);
        a_store_zw("sb",  3'b000, 32'h102, 32'h123456A5, 4'h4, 32'hA5A5A5A5, 32'h100);
        a_store_zw("sh",  3'b001, 32'h106, 32'hFFFF1234, 4'hC, 32'h12341234, 32'h104);
        a_load_zw("lhu",  3'b101, 32'h102, 32'h8001_0000, 4'hC, 32'h0000_8001);
        a_load_zw("lh",   3'b001, 32'h102, 32'h8001_0000, 4'hC, 32'hFFFF_8001);
        a_load_zw("lw",   3'b010, 32'h200, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D);

        // LB 0x103 with ready delayed three cycles
        stalls = 0;
        a_drive(1'b1, 3'b000, 32'h103, 32'd0);
        check("lb_be",   64'(a_be), 64'h8);
        check("lb_addr", 64'(a_req_addr), 64'h100);
        stalls += int'(a_stall);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1 stalls += int'(a_stall);
            check("lb_hold_valid", 64'(a_req_valid), 64'd1);
        end
        @(negedge clk); a_ready = 1;
        #1 stalls += int'(a_stall);
        @(negedge clk); a_ready = 0; a_rsp_valid = 1; a_rdata = 32'h80FF_0000;
        #1 stalls += int'(a_stall);
        check("lb_ldv",  64'(a_ld_valid), 64'd1);
        check("lb_data", 64'(a_ld_data), 64'hFFFF_FF80);
        @(negedge clk); a_rsp_valid = 0;
        #1 check("lb_stall_cycles", 64'(stalls), 64'd4);

        // Misaligned and unsupported-size loads
        a_drive(1'b1, 3'b001, 32'h101, 32'd0);
        check("lh_mis_exc",  64'(a_exc_valid), 64'd1);
        check("lh_mis_code", 64'(a_exc_code), 64'h1);
        check("lh_mis_noreq", 64'(a_req_valid), 64'd0);
        @(negedge clk); #1 check("lh_mis_pulse", 64'(a_exc_valid), 64'd0);
        a_drive(1'b1, 3'b011, 32'h100, 32'd0);
        check("ld32_exc",  64'(a_exc_valid), 64'd1);
        check("ld32_code", 64'(a_exc_code), 64'h2);
        check("ld32_noreq", 64'(a_req_valid), 64'd0);
        a_drive(1'b0, 3'b100, 32'h100, 32'd0);
        check("sbu_code", 64'(a_exc_code), 64'h2);

        // Flush while in WAIT; response two cycles later
        a_ready = 1;
        a_drive(1'b1, 3'b010, 32'h300, 32'd0);
        @(negedge clk); a_ready = 0; a_flush = 1;
        #1 check("fl_stall_wait", 64'(a_stall), 64'd1);
        @(negedge clk); a_flush = 0;
        #1 check("fl_stall_hold", 64'(a_stall), 64'd1);
        @(negedge clk); a_rsp_valid = 1; a_rdata = 32'h1234_5678;
        #1 check("fl_no_ldv", 64'(a_ld_valid), 64'd0);
        check("fl_stall_rel", 64'(a_stall), 64'd0);
        @(negedge clk); a_rsp_valid = 0;
        #1 check("fl_idle", 64'(a_req_valid), 64'd0);

        // Reset in the middle of REQ
        a_drive(1'b1, 3'b010, 32'h400, 32'd0);
        check("rm_req", 64'(a_req_valid), 64'd1);
        rst = 1;
        @(negedge clk); rst = 0;
        #1 check("rm_valid", 64'(a_req_valid), 64'd0);
        check("rm_stall", 64'(a_stall), 64'd0);
        check("rm_addr",  64'(a_req_addr), 64'd0);

        // 64-bit LWU 0x1004
        @(negedge clk);
        b_ex_valid = 1; b_ex_load = 1; b_funct3 = 3'b110; b_addr = 32'h1004; b_ready = 1;
        @(negedge clk); b_ex_valid = 0; b_ex_load = 0;
        #1 check("lwu_be",   64'(b_be), 64'hF0);
        check("lwu_addr", 64'(b_req_addr), 64'h1000);
        @(negedge clk); b_ready = 0; b_rsp_valid = 1; b_rdata = 64'h8000_0001_0000_0000;
        #1 check("lwu_ldv",  64'(b_ld_valid), 64'd1);
        check("lwu_data", b_ld_data, 64'h0000_0000_8000_0001);
        @(negedge clk); b_rsp_valid = 0;

        // 64-bit SD
        @(negedge clk);
        b_ex_valid = 1; b_ex_store = 1; b_funct3 = 3'b011; b_addr = 32'h1008;
        b_wdata = 64'h0123_4567_89AB_CDEF; b_ready = 1;
        @(negedge clk); b_ex_valid = 0; b_ex_store = 0;
        #1 check("sd_be",    64'(b_be), 64'hFF);
        check("sd_wdata", b_req_wdata, 64'h0123_4567_89AB_CDEF);
        @(negedge clk); b_ready = 0;

        // Timeout with ready never asserted (MAX_WAIT=4)
        @(negedge clk);
        b_ex_valid = 1; b_ex_load = 1; b_funct3 = 3'b010; b_addr = 32'h2000;
        @(negedge clk); b_ex_valid = 0; b_ex_load = 0;
        reqs = 0; saw_exc = 0; exc_seen = '0;
        for (int i = 0; i < 10 && !saw_exc; i++) begin
            #1;
            reqs += int'(b_req_valid);
            if (b_exc_valid) begin saw_exc = 1; exc_seen = b_exc_code; end
            @(negedge clk);
        end
        check("to_req_cycles", 64'(reqs), 64'd4);
        check("to_exc_seen",   64'(saw_exc), 64'd1);
        check("to_exc_code",   64'(exc_seen), 64'h3);
        #1 check("to_idle", 64'(b_req_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
